// File: rtl/pwm_capture.sv
// Measures the period and high time of an asynchronous PWM input in clock
// cycles, and flags an input that has stopped toggling as stuck high or low.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             invert,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             sample_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t state, state_nxt;

    logic s1, s2, lvl, lvl_d, rise;

    logic [CNT_W-1:0] per_cnt, per_cnt_nxt;
    logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             sample_valid_nxt, stuck_high_nxt, stuck_low_nxt;

    assign lvl  = s2 ^ invert;
    assign rise = lvl & ~lvl_d;

    // The synchronizer and edge history run regardless of enable, so that
    // re-enabling in the middle of a high phase does not look like a rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            lvl_d <= lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= WAIT_RISE;
            per_cnt      <= '0;
            high_cnt     <= '0;
            idle_cnt     <= '0;
            period       <= '0;
            high_time    <= '0;
            sample_valid <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else begin
            state        <= state_nxt;
            per_cnt      <= per_cnt_nxt;
            high_cnt     <= high_cnt_nxt;
            idle_cnt     <= idle_cnt_nxt;
            period       <= period_nxt;
            high_time    <= high_time_nxt;
            sample_valid <= sample_valid_nxt;
            stuck_high   <= stuck_high_nxt;
            stuck_low    <= stuck_low_nxt;
        end
    end

    // A rise always beats a timeout, so a period of exactly TIMEOUT still
    // yields a valid sample.
    always_comb begin
        state_nxt        = state;
        per_cnt_nxt      = per_cnt;
        high_cnt_nxt     = high_cnt;
        idle_cnt_nxt     = idle_cnt;
        period_nxt       = period;
        high_time_nxt    = high_time;
        sample_valid_nxt = 1'b0;
        stuck_high_nxt   = stuck_high;
        stuck_low_nxt    = stuck_low;

        if (!enable) begin
            state_nxt    = WAIT_RISE;
            per_cnt_nxt  = '0;
            high_cnt_nxt = '0;
            idle_cnt_nxt = '0;
        end else begin
            unique case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        state_nxt    = MEASURE;
                        per_cnt_nxt  = ONE;
                        high_cnt_nxt = ONE;
                        idle_cnt_nxt = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        stuck_high_nxt = lvl;
                        stuck_low_nxt  = ~lvl;
                        idle_cnt_nxt   = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt       = per_cnt;
                        high_time_nxt    = high_cnt;
                        sample_valid_nxt = 1'b1;
                        stuck_high_nxt   = 1'b0;
                        stuck_low_nxt    = 1'b0;
                        per_cnt_nxt      = ONE;
                        high_cnt_nxt     = ONE;
                    end else if (per_cnt == TIMEOUT_CNT) begin
                        stuck_high_nxt = lvl;
                        stuck_low_nxt  = ~lvl;
                        period_nxt     = '0;
                        high_time_nxt  = '0;
                        per_cnt_nxt    = '0;
                        high_cnt_nxt   = '0;
                        idle_cnt_nxt   = '0;
                        state_nxt      = WAIT_RISE;
                    end else begin
                        per_cnt_nxt = per_cnt + ONE;
                        if (lvl) begin
                            high_cnt_nxt = high_cnt + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = WAIT_RISE;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the team's 8-bit PWM generator and is used for loopback self-test and for reading externally generated PWM. When driven by the generator with `enable` held high and duty `D` in 1..254, it reports period 256 and high time `D`. Constant-level inputs (duty 0, duty 255, or a disabled generator) are flagged by timeout.

## Interface
Parameters:
- `CNT_W`, default 16: width of the period and high-time counters and outputs. Must be ≥ 9.
- `TIMEOUT`, default 4096: number of cycles without a rising edge before a stuck flag is raised. Must satisfy 1 < `TIMEOUT` < 2^`CNT_W`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `enable`  in  1  when high, capture runs; when low, capture is held idle.
- `invert`  in  1  when high, the synchronized input is inverted before measurement. Change it only while `enable` is low.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `period`  out  `CNT_W`  last measured period in cycles (rising edge to rising edge).
- `high_time`  out  `CNT_W`  last measured high time in cycles.
- `sample_valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `stuck_high`  out  1  timeout occurred while the input level was 1.
- `stuck_low`  out  1  timeout occurred while the input level was 0.

## Operation
- **Input path:** `pwm_in` passes through a 2-flop synchronizer (s1, s2), then optional inversion giving `lvl`, then a history flop `lvl_d`. A rise is detected when `lvl` = 1 and `lvl_d` = 0.
- **FSM state WAIT_RISE:** counters are held. On a rise: `per_cnt` is set to 1, `high_cnt` is set to 1, and the FSM goes to MEASURE. No sample is emitted, because the first partial period is discarded.
- **FSM state MEASURE, in priority order each cycle:**
  1. **Rise:** `period` is set to `per_cnt` and `high_time` is set to `high_cnt`. `sample_valid` pulses. Both stuck flags clear. `per_cnt` and `high_cnt` restart at 1. The FSM stays in MEASURE.
  2. **Else if `per_cnt` == `TIMEOUT`:** `stuck_high` is set to `lvl` and `stuck_low` is set to ~`lvl`. `period` and `high_time` are cleared to 0 and no `sample_valid` pulse is issued. The FSM goes to WAIT_RISE.
  3. **Else:** `per_cnt` increments. `high_cnt` increments if `lvl` = 1.
- **Timeout from WAIT_RISE:** a separate idle counter in WAIT_RISE also times out after `TIMEOUT` cycles without a rise, setting the stuck flags the same way. This covers an input that is constant from reset. The idle counter restarts after each timeout, so the flags stay asserted.
- **Width rule:** `high_cnt` ≤ `per_cnt` ≤ `TIMEOUT`, so no counter ever wraps. Unsigned arithmetic throughout.
- **`enable` low:**
  - FSM forced to WAIT_RISE.
  - `per_cnt`, `high_cnt` and the idle counter cleared.
  - `sample_valid` = 0.
  - `period`, `high_time` and the stuck flags hold their values.
  - The synchronizer keeps running.
- **Reset (`rst` = 0 at a clock edge), from any state:**
  - All outputs go to 0: `period`, `high_time`, `sample_valid`, `stuck_high`, `stuck_low`.
  - FSM to WAIT_RISE, counters to 0.
  - s1, s2 and `lvl_d` to 0.
  - A reset mid-period discards the partial measurement.

## Timing
- **Latency:** if s1 first captures `pwm_in` = 1 at edge E0, the rise is detected in the cycle after E1. Registered outputs and the `sample_valid` pulse appear after edge E2.
- **`sample_valid`:** high for exactly 1 cycle per rise in MEASURE. Minimum spacing is 2 cycles, for a period of 2.
- **Simultaneous events:**
  - A rise in the same cycle as `per_cnt` == `TIMEOUT`: the rise wins and a valid sample is emitted.
  - `enable` falling in the same cycle as a rise: `enable` wins and no sample is emitted.
- **Minimum measurable widths:** high and low phases must each be ≥ 2 cycles. Narrower pulses may be missed; this is not flagged.

## Test plan
- **Loopback duty 64:** generator with `enable` = 1, `invert` = 0, duty 64 drives `pwm_in` → after the first discarded period, every sample has `period` = 256 and `high_time` = 64, with `sample_valid` pulses 256 cycles apart.
- **Duty 1 and duty 254:** → (256, 1) and (256, 254). Change duty from 64 to 200 mid-run → reports (256, 200) within 2 samples.
- **Constant input:** duty 0 → `stuck_low` = 1 and `period` = 0 exactly `TIMEOUT` cycles after the last rise. Duty 255 → `stuck_high` = 1. Returning to duty 64 → flags clear on the first valid sample.
- **Inversion:** `invert` = 1 on the capture side with duty 64 → `period` = 256, `high_time` = 192.
- **Reset and enable:** `rst` = 0 for 1 cycle mid-period → all outputs 0 on the next cycle, and the next valid sample is the second full period. `enable` dropped for 10 cycles → no `sample_valid` pulse and outputs hold; on re-enable the first partial period is discarded.
- **Simultaneous rise and timeout:** with `TIMEOUT` = 300, drive a square wave of exactly 300-cycle period → `period` = 300, `sample_valid` pulses, and the stuck flags stay 0.
